// File: rtl/btb_pkg.sv
// Shared types, geometry and helpers for the BTB controller and its update queue.
package btb_pkg;

  localparam int SETS     = 8;
  localparam int TAGW     = 27;
  localparam int IDXW     = 3;
  localparam int UQ_DEPTH = 2;

  localparam logic [1:0] ST_SNT   = 2'b00;
  localparam logic [1:0] ST_WNT   = 2'b01;
  localparam logic [1:0] ST_WT    = 2'b10;
  localparam logic [1:0] ST_ST    = 2'b11;
  localparam logic [1:0] ST_ALLOC = ST_WT;

  typedef enum logic {
    IDLE,
    WR
  } upd_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_entry_t;

  function automatic logic [IDXW-1:0] btb_idx(input logic [31:0] pc);
    return pc[IDXW+1:2];
  endfunction

  function automatic logic [TAGW-1:0] btb_tag(input logic [31:0] pc);
    return pc[31:32-TAGW];
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] s);
    return (s == ST_ST) ? s : s + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] s);
    return (s == ST_SNT) ? s : s - 2'd1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates; DEPTH must be a power of 2.
module btb_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count decide what is readable, so stale words are harmless.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB controller: registered 2-way lookup for fetch, plus a queued two-cycle
// read-modify-write engine that borrows the btb_file read port for updates.
module btb_ctrl
  import btb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            lk_valid,
  input  logic [31:0]     lk_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            flush,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [31:0]     upd_pc,
  input  logic            upd_taken,
  input  logic [31:0]     upd_target,
  output logic [IDXW-1:0] bf_rd_set,
  input  logic            bf_rd_valid0,
  input  logic            bf_rd_valid1,
  input  logic [TAGW-1:0] bf_rd_tag0,
  input  logic [TAGW-1:0] bf_rd_tag1,
  input  logic [31:0]     bf_rd_target0,
  input  logic [31:0]     bf_rd_target1,
  input  logic [1:0]      bf_rd_state0,
  input  logic [1:0]      bf_rd_state1,
  input  logic            bf_rd_lru,
  output logic            bf_wr_en,
  output logic [IDXW-1:0] bf_wr_set,
  output logic            bf_wr_way,
  output logic            bf_wr_valid,
  output logic [TAGW-1:0] bf_wr_tag,
  output logic [31:0]     bf_wr_target,
  output logic [1:0]      bf_wr_state,
  output logic            bf_wr_lru_en,
  output logic            bf_wr_lru_val
);

  upd_state_e  state_q, state_d;
  upd_entry_t  push_entry, head;
  logic [$bits(upd_entry_t)-1:0] fifo_dout;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic        cap_hit_q, cap_hit_d;
  logic        cap_way_q, cap_way_d;
  logic [1:0]  cap_state0_q, cap_state0_d;
  logic [1:0]  cap_state1_q, cap_state1_d;
  logic        cap_valid0_q, cap_valid0_d;
  logic        cap_valid1_q, cap_valid1_d;
  logic        cap_lru_q, cap_lru_d;
  logic [31:0] cap_target_q, cap_target_d;

  logic        pred_valid_q, pred_valid_d;
  logic        pred_hit_q, pred_hit_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;

  logic        fsm_rd;
  logic [31:0] cmp_pc;
  logic        hit0, hit1, hit;
  logic [1:0]  sel_state, way_state;
  logic [31:0] sel_target;
  logic        victim;
  logic        unused_pc_lsbs;

  assign upd_ready  = !fifo_full;
  assign fifo_push  = upd_valid && upd_ready;
  assign fifo_pop   = (state_q == WR);
  assign push_entry = '{pc: upd_pc, taken: upd_taken, target: upd_target};
  assign head       = upd_entry_t'(fifo_dout);

  btb_upd_fifo #(
    .DEPTH (UQ_DEPTH),
    .WIDTH ($bits(upd_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The update engine owns the read port in its read cycle; fetch loses that lookup.
  always_comb begin
    fsm_rd     = (state_q == IDLE) && !fifo_empty;
    cmp_pc     = fsm_rd ? head.pc : lk_pc;
    bf_rd_set  = btb_idx(cmp_pc);
    hit0       = bf_rd_valid0 && (bf_rd_tag0 == btb_tag(cmp_pc));
    hit1       = bf_rd_valid1 && (bf_rd_tag1 == btb_tag(cmp_pc));
    hit        = hit0 || hit1;
    sel_state  = hit0 ? bf_rd_state0 : bf_rd_state1;
    sel_target = hit0 ? bf_rd_target0 : bf_rd_target1;
  end

  assign unused_pc_lsbs = ^{cmp_pc[1:0], head.pc[1:0]};

  always_comb begin
    pred_valid_d  = lk_valid && !fsm_rd && !flush;
    pred_hit_d    = 1'b0;
    pred_taken_d  = 1'b0;
    pred_target_d = '0;
    if (pred_valid_d) begin
      pred_hit_d    = hit;
      pred_taken_d  = hit && sel_state[1];
      pred_target_d = pred_taken_d ? sel_target : lk_pc + 32'd4;
    end
  end

  always_comb begin
    state_d      = state_q;
    cap_hit_d    = cap_hit_q;
    cap_way_d    = cap_way_q;
    cap_state0_d = cap_state0_q;
    cap_state1_d = cap_state1_q;
    cap_valid0_d = cap_valid0_q;
    cap_valid1_d = cap_valid1_q;
    cap_lru_d    = cap_lru_q;
    cap_target_d = cap_target_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cap_hit_d    = hit;
          cap_way_d    = !hit0;
          cap_state0_d = bf_rd_state0;
          cap_state1_d = bf_rd_state1;
          cap_valid0_d = bf_rd_valid0;
          cap_valid1_d = bf_rd_valid1;
          cap_lru_d    = bf_rd_lru;
          cap_target_d = sel_target;
          state_d      = WR;
        end
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-back; gated by rst so a reset landing on WR leaves the array untouched.
  always_comb begin
    way_state     = cap_way_q ? cap_state1_q : cap_state0_q;
    victim        = !cap_valid0_q ? 1'b0 : (!cap_valid1_q ? 1'b1 : cap_lru_q);
    bf_wr_en      = 1'b0;
    bf_wr_set     = '0;
    bf_wr_way     = 1'b0;
    bf_wr_valid   = 1'b0;
    bf_wr_tag     = '0;
    bf_wr_target  = '0;
    bf_wr_state   = ST_SNT;
    bf_wr_lru_en  = 1'b0;
    bf_wr_lru_val = 1'b0;
    if ((state_q == WR) && !rst && (cap_hit_q || head.taken)) begin
      bf_wr_en      = 1'b1;
      bf_wr_set     = btb_idx(head.pc);
      bf_wr_valid   = 1'b1;
      bf_wr_tag     = btb_tag(head.pc);
      bf_wr_lru_en  = 1'b1;
      if (cap_hit_q) begin
        bf_wr_way     = cap_way_q;
        bf_wr_state   = head.taken ? sat_inc(way_state) : sat_dec(way_state);
        bf_wr_target  = head.taken ? head.target : cap_target_q;
        bf_wr_lru_val = !cap_way_q;
      end else begin
        bf_wr_way     = victim;
        bf_wr_state   = ST_ALLOC;
        bf_wr_target  = head.target;
        bf_wr_lru_val = !victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cap_hit_q     <= 1'b0;
      cap_way_q     <= 1'b0;
      cap_state0_q  <= '0;
      cap_state1_q  <= '0;
      cap_valid0_q  <= 1'b0;
      cap_valid1_q  <= 1'b0;
      cap_lru_q     <= 1'b0;
      cap_target_q  <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      state_q       <= state_d;
      cap_hit_q     <= cap_hit_d;
      cap_way_q     <= cap_way_d;
      cap_state0_q  <= cap_state0_d;
      cap_state1_q  <= cap_state1_d;
      cap_valid0_q  <= cap_valid0_d;
      cap_valid1_q  <= cap_valid1_d;
      cap_lru_q     <= cap_lru_d;
      cap_target_q  <= cap_target_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule

// File: doc/btb_ctrl.md
# btb_ctrl

BTB controller between the fetch stage, the execute-stage branch resolution, and the `btb_file` storage arrays.
- Each cycle it takes one fetch PC, drives the `btb_file` read port, does the 2-way tag compare, and registers a prediction for the next cycle.
- It queues resolved-branch updates from execute in a small FIFO. Each update is a two-cycle read-modify-write of `btb_file`: 2-bit saturating counter, target and LRU bit.

## Interface
- `SETS`, 8, number of BTB sets; index = `pc[4:2]`.
- `TAGW`, 27, tag width; tag = `pc[31:5]`.
- `UQ_DEPTH`, 2, update FIFO depth (power of 2).

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high (fixed for this block).
- `lk_valid` in 1: fetch lookup request this cycle.
- `lk_pc` in 32: fetch PC.
- `pred_valid` out 1: registered; a lookup result is present.
- `pred_hit` out 1: tag hit in the BTB.
- `pred_taken` out 1: predict taken.
- `pred_target` out 32: predicted next PC.
- `flush` in 1: kills the prediction in flight.
- `upd_valid` in 1: resolved branch from execute.
- `upd_ready` out 1: equals `!fifo_full`.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: actual branch outcome.
- `upd_target` in 32: actual taken target.
- `bf_rd_set` out 3: read set index to `btb_file`.
- `bf_rd_valid0/1` in 1: valid bit of way 0/1.
- `bf_rd_tag0/1` in TAGW: tag of way 0/1.
- `bf_rd_target0/1` in 32: stored target of way 0/1.
- `bf_rd_state0/1` in 2: counter state of way 0/1.
- `bf_rd_lru` in 1: LRU bit of the read set.
- `bf_wr_en`, `bf_wr_set` (3), `bf_wr_way`, `bf_wr_valid`, `bf_wr_tag` (TAGW), `bf_wr_target` (32), `bf_wr_state` (2), `bf_wr_lru_en`, `bf_wr_lru_val` out: write port to `btb_file`. The LRU bit is written to `bf_wr_set`.

## Operation
- **Counter encoding:** 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken iff `state[1]` = 1.
- **LRU bit:** names the victim way. After the write-back that touches way w, `lru = ~w`.
- **Lookup:**
  - `bf_rd_set = lk_pc[4:2]` unless the update FSM owns the read port.
  - Hit_w = `valid_w` && `tag_w == lk_pc[31:5]`. If both ways hit, way 0 wins.
  - `pred_hit` = hit.
  - `pred_taken` = hit && `state[1]`.
  - `pred_target` = the hit way's target if `pred_taken`, else `lk_pc + 4` (mod 2^32).
- **Port steal:** when the FSM reads for an update, the lookup in that cycle is dropped. Next cycle `pred_valid` = 0.
- **FSM IDLE:**
  - If the FIFO is non-empty: `bf_rd_set = head.pc[4:2]`. Capture the compare result, hit way, both states, both valids and `lru` into registers. Go to WR.
  - Otherwise stay in IDLE.
- **FSM WR (pop head, return to IDLE):**
  - **Hit on way w:**
    - Write way w: valid = 1, same tag.
    - State: saturating +1 if taken, −1 if not taken.
    - Target: `upd_target` if taken, else keep the old target.
    - Write LRU = ~w.
  - **Miss and taken:**
    - Victim = way 0 if it is invalid, else way 1 if it is invalid, else `lru`.
    - Write valid = 1, new tag, `upd_target`, state = 10.
    - Write LRU = ~victim.
  - **Miss and not taken:** no array write (`bf_wr_en` = 0, `bf_wr_lru_en` = 0).
- **FIFO:**
  - Push when `upd_valid && upd_ready`. A full FIFO gives `upd_ready` = 0, including in a cycle that also pops.
  - Entry = {pc, taken, target}.
- **Flush:** `flush` in cycle N forces `pred_valid` = 0 in N+1. Flush does not touch the FIFO or the FSM; resolved updates are never dropped.
- **Reset:**
  - FIFO emptied, FSM to IDLE, captured registers cleared.
  - All outputs 0, except `upd_ready` = 1.
  - A reset during WR suppresses that cycle's write.

## Timing
- Lookup latency is 1 cycle: `lk_valid` in cycle N gives `pred_*` valid in N+1, computed from the array contents in cycle N.
- Update accepted in T:
  - Read in T+1.
  - `bf_wr_en` asserted in T+2.
  - Array updated at the end of T+2.
  - First lookup that observes it is in T+3.
- Peak update throughput is 1 per 2 cycles. The port is stolen 1 cycle per update.
- Back-to-back updates to the same set are safe: the second read happens after the first write edge.
- A lookup in the same cycle as WR sees the pre-write contents.

## Structure
- `btb_pkg`:
  - `SETS`, `TAGW`, `IDXW` = 3.
  - Counter encodings `ST_SNT` … `ST_ST` and `ST_ALLOC` = `2'b10`.
  - Functions `btb_idx(pc)`, `btb_tag(pc)`, `sat_inc`, `sat_dec`.
  - FSM state enum `{IDLE, WR}`.
- Sub-module `btb_upd_fifo`: synchronous FIFO, parameterized depth and width, with full/empty flags.

## Test plan
- **Cold miss, then allocate:**
  - Reset, then lookup 0x100 → `pred_valid`=1, `pred_hit`=0, `pred_target`=0x104.
  - Update {0x100, taken, 0x200}, then lookup 0x100 at T+3 → hit, taken, target 0x200.
- **Counter saturation:**
  - Four taken updates to 0x100 → state 11.
  - Three not-taken updates → state 00, and `pred_taken`=0 while `pred_hit`=1.
  - Further decrements stay at 00.
- **Replacement:**
  - Allocate 0x100 and 0x300 (same set 0).
  - Hit-update 0x100, so `lru`=1.
  - Allocate 0x500 → it replaces way 1 (0x300); a lookup of 0x300 misses and 0x100 still hits.
- **Not-taken miss:** update {0x140, not-taken} → no `bf_wr_en` and no LRU write; the lookup still misses.
- **Backpressure and steal:**
  - Drive `upd_valid` for 4 consecutive cycles.
  - `upd_ready` drops after 2 accepts.
  - All accepted updates are applied in order.
  - The lookups in the stolen cycles return `pred_valid`=0.
- **Flush and reset:**
  - `flush` with a lookup → `pred_valid`=0 next cycle, and the queued update is still written.
  - `rst` asserted during WR → no write, and all outputs are back at reset values.
